// File: rtl/lcd_line_writer.sv
// HD44780-style 8-bit LCD writer: power-up wait, init sequence, then one
// 16-character line per start request, padded with spaces after the text.
module lcd_line_writer #(
    parameter int POWERUP_WAIT = 750000,
    parameter int E_HIGH       = 12,
    parameter int CMD_WAIT     = 2500,
    parameter int CLEAR_WAIT   = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] line,
    input  logic [3:0]   length,
    output logic         busy,
    output logic         done,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [7:0]   lcd_data
);

    localparam int MAX_A    = (POWERUP_WAIT > CLEAR_WAIT) ? POWERUP_WAIT : CLEAR_WAIT;
    localparam int MAX_B    = (CMD_WAIT > E_HIGH) ? CMD_WAIT : E_HIGH;
    localparam int MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_WAIT - 1);
    localparam logic [CW-1:0] EH_LAST  = CW'(E_HIGH - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_WAIT - 1);

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR, CHARS, FIN} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_EHIGH, PH_WAIT} phase_t;

    state_t         state_q, state_d;
    phase_t         phase_q;
    logic [CW-1:0]  cnt_q;
    logic [3:0]     idx_q;
    logic [127:0]   line_q;
    logic [3:0]     len_q;

    logic           writing;
    logic           wr_done;
    logic [CW-1:0]  wait_last;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Character i of the line: text is right-aligned, so the first visible
    // character sits (n-1) bytes above the last one.
    function automatic logic [7:0] char_at(input logic [127:0] l,
                                           input logic [3:0] n,
                                           input logic [3:0] i);
        logic [3:0] b;
        b = n - i - 4'd1;
        if (i < n)
            return l[{b, 3'b000} +: 8];
        return 8'h20;
    endfunction

    always_comb begin
        writing   = (state_q == INIT) || (state_q == ADDR) || (state_q == CHARS);
        wait_last = (state_q == INIT && idx_q == 4'd3) ? CLR_LAST : CMD_LAST;
        wr_done   = writing && (phase_q == PH_WAIT) && (cnt_q == wait_last);

        state_d = state_q;
        case (state_q)
            PWRUP: if (cnt_q == PWR_LAST) state_d = INIT;
            INIT:  if (wr_done && idx_q == 4'd3) state_d = IDLE;
            IDLE:  if (start) state_d = ADDR;
            ADDR:  if (wr_done) state_d = CHARS;
            CHARS: if (wr_done && idx_q == 4'd15) state_d = FIN;
            FIN:   state_d = IDLE;
            default: state_d = PWRUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= PWRUP;
        else
            state_q <= state_d;
    end

    // Each bus write walks setup -> E high -> wait; idx advances per write
    // and restarts at zero whenever the FSM moves to a new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_SETUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            line_q  <= '0;
            len_q   <= '0;
        end else begin
            case (state_q)
                PWRUP: cnt_q <= (cnt_q == PWR_LAST) ? '0 : cnt_q + 1'b1;
                IDLE: begin
                    phase_q <= PH_SETUP;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    if (start) begin
                        line_q <= line;
                        len_q  <= length;
                    end
                end
                INIT, ADDR, CHARS: begin
                    case (phase_q)
                        PH_SETUP: begin
                            phase_q <= PH_EHIGH;
                            cnt_q   <= '0;
                        end
                        PH_EHIGH: begin
                            if (cnt_q == EH_LAST) begin
                                phase_q <= PH_WAIT;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        default: begin
                            if (wr_done) begin
                                phase_q <= PH_SETUP;
                                cnt_q   <= '0;
                                idx_q   <= (state_d != state_q) ? 4'd0 : idx_q + 4'd1;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Bus outputs decode straight from registered state, so they hold for
    // the whole write and fall to their reset values the instant rst_n drops.
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == FIN);
        lcd_rw = 1'b0;
        lcd_e  = writing && (phase_q == PH_EHIGH);
        lcd_rs = (state_q == CHARS);
        case (state_q)
            INIT:    lcd_data = init_cmd(idx_q[1:0]);
            ADDR:    lcd_data = 8'h80;
            CHARS:   lcd_data = char_at(line_q, len_q, idx_q);
            default: lcd_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_lcd_line_writer.sv
// Self-checking bench for lcd_line_writer: bus monitor plus a string-level
// model of what one line write should put on the LCD bus.
module tb_lcd_line_writer;

    localparam int PW  = 20;
    localparam int EH  = 2;
    localparam int CMW = 3;
    localparam int CLW = 10;
    localparam int WR  = 1 + EH + CMW;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] line = '0;
    logic [3:0]   length = '0;
    logic         busy, done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]   lcd_data;

    lcd_line_writer #(
        .POWERUP_WAIT(PW), .E_HIGH(EH), .CMD_WAIT(CMW), .CLEAR_WAIT(CLW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .line(line), .length(length),
        .busy(busy), .done(done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor, sampled 1 time unit after each rising edge.
    logic [8:0] wq[$];
    int         rise_q[$];
    int         ehi_q[$];
    int         done_q[$];
    int         setup_err = 0;
    int         stab_err = 0;
    int         ehi = 0;
    logic       e_prev = 1'b0;
    logic [8:0] bus_prev = '0;
    logic [8:0] exp_q[$];

    always @(posedge clk) begin
        #1;
        if (lcd_e && !e_prev) begin
            wq.push_back({lcd_rs, lcd_data});
            rise_q.push_back(cyc);
            if ({lcd_rs, lcd_data} !== bus_prev) setup_err++;
            ehi = 1;
        end else if (lcd_e) begin
            ehi++;
            if ({lcd_rs, lcd_data} !== bus_prev) stab_err++;
        end
        if (!lcd_e && e_prev) ehi_q.push_back(ehi);
        if (done) done_q.push_back(cyc);
        e_prev   = lcd_e;
        bus_prev = {lcd_rs, lcd_data};
    end

    task automatic clear_mon();
        wq.delete(); rise_q.delete(); ehi_q.delete(); done_q.delete();
        setup_err = 0; stab_err = 0;
    endtask

    // Reference: the display shows the last n characters of the 16-byte
    // string, left to right, followed by spaces, after a set-address command.
    task automatic build_model(input logic [127:0] l, input int n);
        logic [7:0] text[16];
        for (int k = 0; k < 16; k++) text[k] = l[8*(15-k) +: 8];
        exp_q.delete();
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++)
            exp_q.push_back(i < n ? {1'b1, text[16-n+i]} : 9'h120);
    endtask

    task automatic test_reset();
        #3;
        tests_run++;
        if ({busy, done, lcd_e, lcd_rs, lcd_rw, lcd_data} !== {5'b10000, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%b required=%b",
                     {busy, done, lcd_e, lcd_rs, lcd_rw, lcd_data}, {5'b10000, 8'h00});
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (lcd_e !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_held e=%b busy=%b required e=0 busy=1", lcd_e, busy);
        end
    endtask

    task automatic test_powerup(input bit hold_start);
        int r, idle_c;
        logic [8:0] init_exp[4];
        init_exp = '{9'h038, 9'h00C, 9'h006, 9'h001};
        clear_mon();
        start = hold_start;
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        idle_c = -1;
        for (int i = 0; i < 300 && idle_c < 0; i++) begin
            @(negedge clk);
            if (busy === 1'b0) idle_c = cyc;
        end
        start = 1'b0;
        tests_run++;
        if (idle_c != r + PW + 3*WR + (1 + EH + CLW)) begin
            tests_failed++;
            $display("FAIL powerup_idle_cycle got=%0d required=%0d", idle_c - r,
                     PW + 3*WR + 1 + EH + CLW);
        end
        tests_run++;
        if (wq.size() != 4) begin
            tests_failed++;
            $display("FAIL init_write_count got=%0d required=4", wq.size());
        end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            tests_run++;
            if (wq[i] !== init_exp[i]) begin
                tests_failed++;
                $display("FAIL init_cmd%0d got=%h required=%h", i, wq[i], init_exp[i]);
            end
        end
        tests_run++;
        if (rise_q.size() == 0 || rise_q[0] != r + PW + 1) begin
            tests_failed++;
            $display("FAIL powerup_first_e got=%0d required=%0d",
                     rise_q.size() ? rise_q[0] - r : -1, PW + 1);
        end
        for (int i = 1; i < rise_q.size(); i++) begin
            tests_run++;
            if (rise_q[i] - rise_q[i-1] != WR) begin
                tests_failed++;
                $display("FAIL init_gap%0d got=%0d required=%0d", i, rise_q[i] - rise_q[i-1], WR);
            end
        end
        tests_run++;
        if (setup_err != 0 || stab_err != 0 || ehi_q.size() != 4) begin
            tests_failed++;
            $display("FAIL init_strobe setup_err=%0d stab_err=%0d pulses=%0d required 0 0 4",
                     setup_err, stab_err, ehi_q.size());
        end
        repeat (20) @(negedge clk);
        tests_run++;
        if (wq.size() != 4 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_quiet writes=%0d busy=%b required 4 0", wq.size(), busy);
        end
    endtask

    task automatic test_line(input string name, input logic [127:0] l, input int n,
                             input bit disturb);
        int sc;
        clear_mon();
        build_model(l, n);
        @(negedge clk);
        line = l; length = n[3:0]; start = 1'b1;
        sc = cyc;
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            for (int i = 0; i < 100 && wq.size() < 6; i++) @(negedge clk);
            line   = {$urandom(), $urandom(), $urandom(), $urandom()};
            length = 4'($urandom_range(0, 15));
            start  = 1'b1;
            @(negedge clk);
            start  = 1'b0;
        end
        for (int i = 0; i < 300 && done_q.size() == 0; i++) @(negedge clk);
        tests_run++;
        if (done_q.size() == 0 || done_q[0] != sc + 17*WR + 1) begin
            tests_failed++;
            $display("FAIL %s done_cycle got=%0d required=%0d", name,
                     done_q.size() ? done_q[0] - sc : -1, 17*WR + 1);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || done_q.size() != 1) begin
            tests_failed++;
            $display("FAIL %s done_pulse done=%b busy=%b pulses=%0d required 0 0 1",
                     name, done, busy, done_q.size());
        end
        tests_run++;
        if (wq.size() != 17) begin
            tests_failed++;
            $display("FAIL %s write_count got=%0d required=17", name, wq.size());
        end
        for (int i = 0; i < 17 && i < wq.size(); i++) begin
            tests_run++;
            if (wq[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL %s byte%0d got=%h required=%h", name, i, wq[i], exp_q[i]);
            end
        end
        for (int i = 1; i < rise_q.size(); i++) begin
            tests_run++;
            if (rise_q[i] - rise_q[i-1] != WR) begin
                tests_failed++;
                $display("FAIL %s gap%0d got=%0d required=%0d", name, i,
                         rise_q[i] - rise_q[i-1], WR);
            end
        end
        foreach (ehi_q[i]) begin
            tests_run++;
            if (ehi_q[i] != EH) begin
                tests_failed++;
                $display("FAIL %s e_width%0d got=%0d required=%0d", name, i, ehi_q[i], EH);
            end
        end
        tests_run++;
        if (setup_err != 0 || stab_err != 0 || lcd_rw !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s bus_stable setup_err=%0d stab_err=%0d rw=%b required 0 0 0",
                     name, setup_err, stab_err, lcd_rw);
        end
        if (disturb) begin
            repeat (150) @(negedge clk);
            tests_run++;
            if (wq.size() != 17 || done_q.size() != 1) begin
                tests_failed++;
                $display("FAIL %s no_second_write writes=%0d dones=%0d required 17 1",
                         name, wq.size(), done_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        build_model({$urandom(), $urandom(), $urandom(), $urandom()}, 12);
        @(negedge clk);
        line = {$urandom(), $urandom(), $urandom(), $urandom()};
        length = 4'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && wq.size() < 9; i++) @(negedge clk);
        tests_run++;
        if (lcd_e !== 1'b1 || wq.size() != 9) begin
            tests_failed++;
            $display("FAIL midreset_reach_write7 e=%b writes=%0d required 1 9", lcd_e, wq.size());
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, lcd_e, lcd_rs, lcd_data} !== {4'b1000, 8'h00}) begin
            tests_failed++;
            $display("FAIL midreset_immediate got=%b required=%b",
                     {busy, done, lcd_e, lcd_rs, lcd_data}, {4'b1000, 8'h00});
        end
        repeat (2) @(negedge clk);
        test_powerup(1'b0);
    endtask

    initial begin
        test_reset();
        test_powerup(1'b1);
        test_line("nop", 128'h6E6F70, 3, 1'b0);
        test_line("len0", {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1'b0);
        test_line("lod", "lod r3, 0x00FF", 14, 1'b0);
        test_line("full", "0123456789ABCDEF", 15, 1'b0);
        for (int t = 0; t < 4; t++)
            test_line("rand", {$urandom(), $urandom(), $urandom(), $urandom()},
                      $urandom_range(0, 15), 1'b0);
        test_line("midchg", {$urandom(), $urandom(), $urandom(), $urandom()},
                  $urandom_range(6, 15), 1'b1);
        test_reset_mid();
        test_line("after_reset", "hello", 5, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
